// File: rtl/sid_svf_serial.sv
// Chamberlin state-variable filter (HP/BP/LP) with bit-serial shift-add multiplies, saturating
// additive mode mix, volume scaling and a one-cycle out_valid strobe. Optional: SID_SVF_CLIP_CNT_EN.
module sid_svf_serial #(
    parameter int DATA_W  = 8,
    parameter int FC_W    = 11,
    parameter int FC_FRAC = 14,
    parameter int STATE_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic [FC_W-1:0]   fc,
    input  logic [3:0]        res,
    input  logic              filt_en,
    input  logic [2:0]        mode,
    input  logic [3:0]        vol,
    output logic [DATA_W-1:0] sample_out,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun,
    output logic [7:0]        clip_cnt
);

    localparam int G  = STATE_W - DATA_W - 2;
    localparam int PW = STATE_W + FC_W;
    localparam int WW = PW + 2;
    localparam int CW = $clog2(FC_W + 1);

    localparam logic signed [WW-1:0] ST_MAX = WW'((64'sd1 <<< (STATE_W - 1)) - 64'sd1);
    localparam logic signed [WW-1:0] ST_MIN = ~ST_MAX;
    localparam logic signed [WW-1:0] D_MAX  = WW'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [WW-1:0] D_MIN  = ~D_MAX;
    localparam logic signed [WW-1:0] HALF_W = WW'(64'sd1 <<< (DATA_W - 1));

    typedef enum logic [2:0] {
        S_IDLE, S_DAMP, S_MUL_BP, S_MUL_LP, S_MIX, S_VOL
    } state_t;

    function automatic logic signed [STATE_W-1:0] sat_st(input logic signed [WW-1:0] v);
        if (v > ST_MAX) return ST_MAX[STATE_W-1:0];
        if (v < ST_MIN) return ST_MIN[STATE_W-1:0];
        return v[STATE_W-1:0];
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_dw(input logic signed [WW-1:0] v);
        if (v > D_MAX) return D_MAX[DATA_W-1:0];
        if (v < D_MIN) return D_MIN[DATA_W-1:0];
        return v[DATA_W-1:0];
    endfunction

    function automatic logic signed [WW-1:0] sext_st(input logic signed [STATE_W-1:0] v);
        return {{(WW-STATE_W){v[STATE_W-1]}}, v};
    endfunction

    function automatic logic signed [WW-1:0] sext_dw(input logic signed [DATA_W-1:0] v);
        return {{(WW-DATA_W){v[DATA_W-1]}}, v};
    endfunction

    state_t                    state_q;
    logic [DATA_W-1:0]         smp_q;
    logic [DATA_W-1:0]         sample_out_q;
    logic                      out_valid_q;
    logic [FC_W-1:0]           fc_q;
    logic [FC_W-1:0]           mplier_q;
    logic [3:0]                res_q;
    logic [3:0]                vol_q;
    logic [2:0]                mode_q;
    logic signed [STATE_W-1:0] hp_q;
    logic signed [STATE_W-1:0] bp_q;
    logic signed [STATE_W-1:0] lp_q;
    logic signed [PW-1:0]      acc_q;
    logic signed [PW-1:0]      mcand_q;
    logic [CW-1:0]             bit_cnt_q;

    logic                      accept;
    logic                      bypass;
    logic                      last_bit;
    logic [3:0]                q_w;
    logic signed [WW-1:0]      x_w;
    logic signed [WW-1:0]      bpq_w;
    logic signed [WW-1:0]      d_w;
    logic signed [WW-1:0]      hp_sum_w;
    logic signed [STATE_W-1:0] hp_d;
    logic signed [PW-1:0]      acc_d;
    logic signed [WW-1:0]      prod_w;
    logic signed [WW-1:0]      upd_sum_w;
    logic signed [STATE_W-1:0] upd_d;
    logic signed [WW-1:0]      lp_sh_w;
    logic signed [WW-1:0]      bp_sh_w;
    logic signed [WW-1:0]      hp_sh_w;
    logic signed [WW-1:0]      mix_sum_w;
    logic signed [DATA_W-1:0]  mix_d;
    logic [DATA_W-1:0]         u_w;
    logic [DATA_W-1:0]         sample_out_d;

    always_comb begin
        accept    = sample_valid && (state_q == S_IDLE);
        bypass    = !filt_en || (mode == 3'b000);
        last_bit  = (bit_cnt_q == CW'(FC_W - 1));
        q_w       = (res_q == 4'hF) ? 4'd1 : 4'd15 - res_q;

        // Offset-binary sample to signed, aligned onto the integrator's fractional grid.
        x_w       = ({{(WW-DATA_W){1'b0}}, smp_q} - HALF_W) <<< G;
        bpq_w     = sext_st(bp_q) * $signed({{(WW-4){1'b0}}, q_w});
        d_w       = bpq_w >>> 3;
        hp_sum_w  = x_w - sext_st(lp_q) - d_w;
        hp_d      = sat_st(hp_sum_w);

        // One multiplier bit per cycle; the final shift is arithmetic, so the product floors.
        acc_d     = acc_q + (mplier_q[0] ? mcand_q : {PW{1'b0}});
        prod_w    = $signed({{(WW-PW){acc_d[PW-1]}}, acc_d}) >>> FC_FRAC;
        upd_sum_w = sext_st((state_q == S_MUL_BP) ? bp_q : lp_q) + prod_w;
        upd_d     = sat_st(upd_sum_w);

        lp_sh_w   = sext_st(lp_q) >>> G;
        bp_sh_w   = sext_st(bp_q) >>> G;
        hp_sh_w   = sext_st(hp_q) >>> G;
        mix_sum_w = '0;
        if (mode_q[0]) mix_sum_w = mix_sum_w + sext_dw(sat_dw(lp_sh_w));
        if (mode_q[1]) mix_sum_w = mix_sum_w + sext_dw(sat_dw(bp_sh_w));
        if (mode_q[2]) mix_sum_w = mix_sum_w + sext_dw(sat_dw(hp_sh_w));
        mix_d     = sat_dw(mix_sum_w);
        u_w       = {~mix_d[DATA_W-1], mix_d[DATA_W-2:0]};
        sample_out_d = DATA_W'(({4'b0000, u_w} * {{DATA_W{1'b0}}, vol_q}) >> 4);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            smp_q        <= '0;
            sample_out_q <= '0;
            out_valid_q  <= 1'b0;
            fc_q         <= '0;
            mplier_q     <= '0;
            res_q        <= '0;
            vol_q        <= '0;
            mode_q       <= '0;
            hp_q         <= '0;
            bp_q         <= '0;
            lp_q         <= '0;
            acc_q        <= '0;
            mcand_q      <= '0;
            bit_cnt_q    <= '0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (bypass) begin
                            sample_out_q <= sample_in;
                            out_valid_q  <= 1'b1;
                        end else begin
                            smp_q   <= sample_in;
                            fc_q    <= fc;
                            res_q   <= res;
                            mode_q  <= mode;
                            vol_q   <= vol;
                            state_q <= S_DAMP;
                        end
                    end
                end
                S_DAMP: begin
                    hp_q      <= hp_d;
                    mcand_q   <= {{FC_W{hp_d[STATE_W-1]}}, hp_d};
                    mplier_q  <= fc_q;
                    acc_q     <= '0;
                    bit_cnt_q <= '0;
                    state_q   <= S_MUL_BP;
                end
                S_MUL_BP, S_MUL_LP: begin
                    acc_q     <= acc_d;
                    mcand_q   <= mcand_q <<< 1;
                    mplier_q  <= mplier_q >> 1;
                    bit_cnt_q <= bit_cnt_q + CW'(1);
                    if (last_bit) begin
                        acc_q     <= '0;
                        bit_cnt_q <= '0;
                        if (state_q == S_MUL_BP) begin
                            bp_q     <= upd_d;
                            mcand_q  <= {{FC_W{upd_d[STATE_W-1]}}, upd_d};
                            mplier_q <= fc_q;
                            state_q  <= S_MUL_LP;
                        end else begin
                            lp_q    <= upd_d;
                            state_q <= S_MIX;
                        end
                    end
                end
                S_MIX: begin
                    sample_out_q <= sample_out_d;
                    out_valid_q  <= 1'b1;
                    state_q      <= S_VOL;
                end
                S_VOL: begin
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sample_out = sample_out_q;
    assign out_valid  = out_valid_q;
    assign busy       = (state_q != S_IDLE);
    assign overrun    = sample_valid && busy;

`ifdef SID_SVF_CLIP_CNT_EN
    function automatic logic ovf_st(input logic signed [WW-1:0] v);
        return (v > ST_MAX) || (v < ST_MIN);
    endfunction

    function automatic logic ovf_dw(input logic signed [WW-1:0] v);
        return (v > D_MAX) || (v < D_MIN);
    endfunction

    logic       clip_q;
    logic       clip_evt;
    logic [7:0] clip_cnt_q;

    // Every clamp within one sample collapses into a single event, counted at mix time.
    always_comb begin
        clip_evt = clip_q || ovf_dw(mix_sum_w)
                || (mode_q[0] && ovf_dw(lp_sh_w))
                || (mode_q[1] && ovf_dw(bp_sh_w))
                || (mode_q[2] && ovf_dw(hp_sh_w));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clip_q     <= 1'b0;
            clip_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE:   if (accept) clip_q <= 1'b0;
                S_DAMP:   if (ovf_st(hp_sum_w)) clip_q <= 1'b1;
                S_MUL_BP,
                S_MUL_LP: if (last_bit && ovf_st(upd_sum_w)) clip_q <= 1'b1;
                S_MIX:    if (clip_evt && (clip_cnt_q != 8'hFF)) clip_cnt_q <= clip_cnt_q + 8'd1;
                default:  ;
            endcase
        end
    end

    assign clip_cnt = clip_cnt_q;
`else
    assign clip_cnt = 8'd0;
`endif

endmodule
